// File: rtl/hazard_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hazard_pkg
// Purpose  : Shared types and constants for the RV32I pipeline hazard unit:
//            forward-select encoding, register-index width, and the
//            result-source code that marks a load.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int FWD_W      = 2;

  // The decode stage tags loads with this result-source code
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Operand select for the execute-stage source muxes
  typedef enum logic [FWD_W-1:0] {
    FWD_RD  = 2'b00,  // register-file read data carried in ID/EX
    FWD_WB  = 2'b01,  // writeback-stage result
    FWD_MEM = 2'b10   // memory-stage ALU result
  } fwd_sel_t;

  // Forwarding is only meaningful for a real, nonzero destination register
  function automatic logic writes_reg(input logic we,
                                      input logic [REG_ADDR_W-1:0] rd);
    return we && (rd != '0);
  endfunction

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hazard_fwd_sel
// Purpose  : Priority compare for one execute-stage source operand. The
//            memory stage holds the youngest result, so it wins over the
//            writeback stage. Register x0 is never forwarded.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  output fwd_sel_t              fwd
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

  // Youngest producer first: memory stage, then writeback, else register file
  always_comb begin
    fwd = FWD_RD;
    if (hit_m) begin
      fwd = FWD_MEM;
    end else if (hit_w) begin
      fwd = FWD_WB;
    end
  end

endmodule : hazard_fwd_sel
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hazard_unit
// Purpose  : Hazard detection for the 5-stage RV32I pipeline. Tracks its own
//            shadow copy of E/M/W destination and write-enable fields and
//            produces the execute-stage forward selects, load-use stalls and
//            branch flushes.
// Options  : HAZARD_PERF_CNT_EN - adds saturating 32-bit StallCnt/FlushCnt
//            outputs counting load-use stall cycles and taken-branch cycles.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int FWD_W      = hazard_pkg::FWD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] RdD,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  PCSrcE,
  output logic [FWD_W-1:0]      ForwardAE,
  output logic [FWD_W-1:0]      ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD,
  output logic                  FlushE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           StallCnt,
  output logic [31:0]           FlushCnt
`endif
);

  // Shadow pipeline state
  logic [REG_ADDR_W-1:0] rs1_e;
  logic [REG_ADDR_W-1:0] rs2_e;
  logic [REG_ADDR_W-1:0] rd_e;
  logic                  reg_write_e;
  logic                  load_e;
  logic [REG_ADDR_W-1:0] rd_m;
  logic                  reg_write_m;
  logic [REG_ADDR_W-1:0] rd_w;
  logic                  reg_write_w;

  logic                  lw_stall;
  logic                  flush_e;
  fwd_sel_t              fwd_a;
  fwd_sel_t              fwd_b;

  // Load in E whose destination is read by the instruction in D
  assign lw_stall = load_e && (rd_e != '0) && ((rd_e == Rs1D) || (rd_e == Rs2D));

  // A taken branch discards both younger instructions; a load-use hazard
  // inserts one bubble into E while F and D hold.
  assign flush_e = lw_stall || PCSrcE;

  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushD = PCSrcE;
  assign FlushE = flush_e;

  // E stage captures the decode fields or a bubble when flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
    end else if (flush_e) begin
      rs1_e       <= '0;
      rs2_e       <= '0;
      rd_e        <= '0;
      reg_write_e <= 1'b0;
      load_e      <= 1'b0;
    end else begin
      rs1_e       <= Rs1D;
      rs2_e       <= Rs2D;
      rd_e        <= RdD;
      reg_write_e <= RegWriteD;
      load_e      <= (ResultSrcD == RESULT_SRC_LOAD);
    end
  end

  // M and W stages advance every cycle; they are never stalled or flushed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_m        <= '0;
      reg_write_m <= 1'b0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else begin
      rd_m        <= rd_e;
      reg_write_m <= reg_write_e;
      rd_w        <= rd_m;
      reg_write_w <= reg_write_m;
    end
  end

  hazard_fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_a)
  );

  hazard_fwd_sel #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd         (fwd_b)
  );

  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  // Saturating event counters; they stick at all-ones rather than wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (lw_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (PCSrcE && (flush_cnt != 32'hFFFF_FFFF)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign StallCnt = stall_cnt;
  assign FlushCnt = flush_cnt;
`endif

endmodule : hazard_unit
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_hazard_unit
// Purpose  : Self-checking bench for hazard_unit. A reference model holds the
//            in-flight instructions as records in an E/M/W array and derives
//            the expected hazard outputs from them each cycle.
// Options  : HAZARD_PERF_CNT_EN - also checks StallCnt/FlushCnt.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    bit         we;
    bit         ld;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] Rs1D = '0;
  logic [4:0] Rs2D = '0;
  logic [4:0] RdD = '0;
  logic       RegWriteD = 1'b0;
  logic [1:0] ResultSrcD = '0;
  logic       PCSrcE = 1'b0;
  logic [1:0] ForwardAE;
  logic [1:0] ForwardBE;
  logic       StallF;
  logic       StallD;
  logic       FlushD;
  logic       FlushE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] StallCnt;
  logic [31:0] FlushCnt;
  int unsigned m_stall_cnt = 0;
  int unsigned m_flush_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // pipe[0]=E, pipe[1]=M, pipe[2]=W
  instr_t pipe [3];

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .ResultSrcD (ResultSrcD),
    .PCSrcE     (PCSrcE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, we: 1'b0, ld: 1'b0};
  endfunction

  // Nearest older producer of a nonzero register supplies the operand
  function automatic logic [1:0] model_fwd(input logic [4:0] rs);
    for (int s = 1; s <= 2; s++) begin
      if (pipe[s].we && pipe[s].rd != 0 && pipe[s].rd == rs)
        return (s == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  function automatic bit model_lw();
    return pipe[0].ld && pipe[0].rd != 0 && (pipe[0].rd == Rs1D || pipe[0].rd == Rs2D);
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [1:0] rsrc, input logic br);
    Rs1D = rs1; Rs2D = rs2; RdD = rd; RegWriteD = we; ResultSrcD = rsrc; PCSrcE = br;
    #1;
  endtask

  task automatic check_all(input string tag);
    bit lw;
    lw = model_lw();
    check({tag, ".fwdA"},   {30'd0, ForwardAE}, {30'd0, model_fwd(pipe[0].rs1)});
    check({tag, ".fwdB"},   {30'd0, ForwardBE}, {30'd0, model_fwd(pipe[0].rs2)});
    check({tag, ".stallF"}, {31'd0, StallF}, {31'd0, lw});
    check({tag, ".stallD"}, {31'd0, StallD}, {31'd0, lw});
    check({tag, ".flushD"}, {31'd0, FlushD}, {31'd0, PCSrcE});
    check({tag, ".flushE"}, {31'd0, FlushE}, {31'd0, lw | PCSrcE});
  endtask

  // Advance the model by one clock with the currently driven D fields
  task automatic tick();
    bit lw;
    lw = model_lw();
`ifdef HAZARD_PERF_CNT_EN
    if (lw) m_stall_cnt++;
    if (PCSrcE) m_flush_cnt++;
`endif
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (lw || PCSrcE)
      pipe[0] = '{rs1: 5'd0, rs2: 5'd0, rd: 5'd0, we: 1'b0, ld: 1'b0};
    else
      pipe[0] = '{rs1: Rs1D, rs2: Rs2D, rd: RdD, we: RegWriteD, ld: (ResultSrcD == 2'b01)};
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic we, input logic [1:0] rsrc, input logic br, input string tag);
    drive(rs1, rs2, rd, we, rsrc, br);
    check_all(tag);
    tick();
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, "nop");
  endtask

  initial begin
    model_clear();
    // Reset held for two cycles, then released away from the clock edge
    repeat (2) @(posedge clk);
    #1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    check_all("reset");
    rst_n = 1'b1;
    step(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, "idle");
    check("idle.fwdA0", {30'd0, ForwardAE}, 32'd0);

    // EX->EX then WB forward on source A
    step(5'd1, 5'd2, 5'd5, 1'b1, 2'b00, 1'b0, "add5");
    step(5'd5, 5'd4, 5'd6, 1'b1, 2'b00, 1'b0, "sub");
    drive(5'd5, 5'd0, 5'd9, 1'b1, 2'b00, 1'b0);
    check_all("exfwd");
    check("exfwd.fwdA", {30'd0, ForwardAE}, 32'd2);
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    check_all("wbfwd");
    check("wbfwd.fwdA", {30'd0, ForwardAE}, 32'd1);
    tick();
    nops(3);

    // Two writes to x7: memory stage wins
    step(5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0, "w7a");
    step(5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 1'b0, "w7b");
    step(5'd0, 5'd7, 5'd8, 1'b0, 2'b00, 1'b0, "r7");
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    check("prio.fwdB", {30'd0, ForwardBE}, 32'd2);
    check_all("prio");
    tick();
    nops(3);

    // Same with x0: never forwarded
    step(5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0, "w0a");
    step(5'd0, 5'd0, 5'd0, 1'b1, 2'b00, 1'b0, "w0b");
    step(5'd0, 5'd0, 5'd8, 1'b0, 2'b00, 1'b0, "r0");
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    check("x0.fwdB", {30'd0, ForwardBE}, 32'd0);
    check_all("x0");
    tick();
    nops(3);

    // Load-use: one stall cycle, then the consumer gets the WB result
    step(5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 1'b0, "ld3");
    drive(5'd3, 5'd0, 5'd4, 1'b1, 2'b00, 1'b0);
    check("lu.stallF", {31'd0, StallF}, 32'd1);
    check("lu.flushE", {31'd0, FlushE}, 32'd1);
    check_all("lu");
    tick();
    drive(5'd3, 5'd0, 5'd4, 1'b1, 2'b00, 1'b0);
    check("lu2.stallD", {31'd0, StallD}, 32'd0);
    check_all("lu2");
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    check("lu3.fwdA", {30'd0, ForwardAE}, 32'd1);
    check_all("lu3");
    tick();
    nops(3);

    // Branch taken in the load-use cycle
    step(5'd0, 5'd0, 5'd3, 1'b1, 2'b01, 1'b0, "ld3b");
    drive(5'd3, 5'd0, 5'd4, 1'b1, 2'b00, 1'b1);
    check("br.all", {28'd0, StallF, StallD, FlushD, FlushE}, 32'hF);
    check_all("br");
    tick();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0);
    check("br2.fwdA", {30'd0, ForwardAE}, 32'd0);
    check_all("br2");
    tick();

    // Random traffic over a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom), 2'($urandom), 1'($urandom_range(0, 7) == 0), "rnd");
      if (i == 200) begin
        // Asynchronous reset mid-stream: outputs clear before any clock edge
        drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'd1, 1'b1, 2'b01, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
`ifdef HAZARD_PERF_CNT_EN
        m_stall_cnt = 0;
        m_flush_cnt = 0;
        check("arst.stallcnt", StallCnt, 32'd0);
        check("arst.flushcnt", FlushCnt, 32'd0);
`endif
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
      end
    end

`ifdef HAZARD_PERF_CNT_EN
    check("cnt.stall", StallCnt, m_stall_cnt);
    check("cnt.flush", FlushCnt, m_flush_cnt);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hazard_unit
`default_nettype wire
